// File: rtl/fdd_motor_seq.sv
// fdd_motor_seq: floppy spindle motor and head-ready sequencer.
// Turns the controller head-load request and the drive select into a gated
// motor, a one-hot drive select, a delayed head-ready and a disk-present flag.
// Optional: define FDD_MOTOR_SEQ_INDEX_QUAL_EN to require INDEX_MIN index
// edges during spin-up (with a 3*SPINUP_MS fallback).
module fdd_motor_seq #(
    parameter int CLK_HZ       = 28000000,
    parameter int SPINUP_MS    = 500,
    parameter int SETTLE_MS    = 30,
    parameter int IDLE_MS      = 2000,
    parameter int INDEX_TMO_MS = 1000,
    parameter int INDEX_MIN    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hld_req,
    input  logic [1:0] ds,
    input  logic       index_n,
    input  logic       wg,
    input  logic       step,
    output logic       motor,
    output logic [3:0] ds_out,
    output logic       hrdy,
    output logic       disk_present,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_SPINUP = 3'd1,
        S_SETTLE = 3'd2,
        S_READY  = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam int            DIV         = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
    localparam int            PW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX     = PW'(DIV - 1);
    localparam logic [11:0]   SPINUP_T    = 12'(SPINUP_MS);
    localparam logic [11:0]   SETTLE_T    = 12'(SETTLE_MS);
    localparam logic [11:0]   IDLE_T      = 12'(IDLE_MS);
    localparam logic [11:0]   INDEX_TMO_T = 12'(INDEX_TMO_MS);
    localparam logic [11:0]   MS_SAT      = 12'hFFF;

    state_t        state_q, state_nxt;
    logic [PW-1:0] pre;
    logic          tick;
    logic          idx_s1, idx_s2, idx_s3;
    logic          idx_edge;
    logic [1:0]    drv, drv_nxt;
    logic          hold_flag, flag_nxt;
    logic [11:0]   ms_cnt, ms_nxt;
    logic [11:0]   idx_ms, idx_ms_nxt;
    logic          drv_chg, entry, keep_ms, spin_done;
    logic          motor_nxt, hrdy_nxt, dp_nxt;
    logic [3:0]    ds_out_nxt;

    assign state    = state_q;
    assign idx_edge = idx_s3 & ~idx_s2;

    // Free-running 1 ms prescaler; tick is a one-cycle pulse at wrap.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre  <= '0;
            tick <= 1'b0;
        end else if (pre == PRE_MAX) begin
            pre  <= '0;
            tick <= 1'b1;
        end else begin
            pre  <= pre + 1'b1;
            tick <= 1'b0;
        end
    end

    // Two-flop synchronizer for the raw index pulse plus a delay flop for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_s1 <= 1'b1;
            idx_s2 <= 1'b1;
            idx_s3 <= 1'b1;
        end else begin
            idx_s1 <= index_n;
            idx_s2 <= idx_s1;
            idx_s3 <= idx_s2;
        end
    end

`ifdef FDD_MOTOR_SEQ_INDEX_QUAL_EN
    localparam logic [11:0] SPIN_TMO_T = 12'(3 * SPINUP_MS);
    localparam logic [2:0]  EDGE_MIN   = 3'(INDEX_MIN);

    logic [2:0] edge_cnt;

    // Count index edges seen during spin-up; restarted on every SPINUP entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            edge_cnt <= '0;
        else if (entry && state_nxt == S_SPINUP)
            edge_cnt <= '0;
        else if (state_q == S_SPINUP && idx_edge && edge_cnt != 3'h7)
            edge_cnt <= edge_cnt + 1'b1;
    end

    // Spin-up ends once the disk is seen turning, or after a fallback timeout.
    assign spin_done = ((ms_cnt >= SPINUP_T) && (edge_cnt >= EDGE_MIN)) ||
                       (ms_cnt >= SPIN_TMO_T);
`else
    assign spin_done = (ms_cnt >= SPINUP_T);
`endif

    // Next-state, counter and output decode.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state_q;
        drv_nxt   = drv;
        flag_nxt  = hold_flag;
        keep_ms   = 1'b0;
        drv_chg   = (state_q != S_OFF) && (ds != drv);

        case (state_q)
            S_OFF: begin
                if (hld_req) begin
                    state_nxt = S_SPINUP;
                    drv_nxt   = ds;
                end
            end
            S_SPINUP: begin
                if (!hld_req) begin
                    state_nxt = S_HOLD;
                    flag_nxt  = 1'b0;
                end else if (spin_done) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!hld_req) begin
                    state_nxt = S_HOLD;
                    flag_nxt  = 1'b0;
                end else if (ms_cnt >= SETTLE_T) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (!hld_req) begin
                    state_nxt = S_HOLD;
                    flag_nxt  = 1'b1;
                end
            end
            S_HOLD: begin
                if (hld_req) begin
                    if (hold_flag) begin
                        state_nxt = S_READY;
                    end else begin
                        state_nxt = S_SPINUP;
                        keep_ms   = 1'b1;
                    end
                end else if (!(wg || step) && ms_cnt >= IDLE_T) begin
                    state_nxt = S_OFF;
                    flag_nxt  = 1'b0;
                end
            end
            default: state_nxt = S_OFF;
        endcase

        // A new drive always restarts spin-up, overriding anything above.
        if (drv_chg) begin
            state_nxt = S_SPINUP;
            drv_nxt   = ds;
            flag_nxt  = 1'b0;
            keep_ms   = 1'b0;
        end

        entry = (state_nxt != state_q) || drv_chg;

        if (entry && !keep_ms)
            ms_nxt = '0;
        else if (state_q == S_HOLD && state_nxt == S_HOLD && (wg || step))
            ms_nxt = '0;
        else if (tick && ms_cnt != MS_SAT)
            ms_nxt = ms_cnt + 1'b1;
        else
            ms_nxt = ms_cnt;

        if (state_nxt == S_OFF)
            idx_ms_nxt = INDEX_TMO_T;
        else if (idx_edge)
            idx_ms_nxt = '0;
        else if (tick && motor && idx_ms != MS_SAT)
            idx_ms_nxt = idx_ms + 1'b1;
        else
            idx_ms_nxt = idx_ms;

        motor_nxt  = (state_nxt != S_OFF);
        hrdy_nxt   = (state_nxt == S_READY) || (state_nxt == S_HOLD && flag_nxt);
        ds_out_nxt = motor_nxt ? (4'b0001 << drv_nxt) : 4'b0000;
        dp_nxt     = motor_nxt && (idx_ms_nxt < INDEX_TMO_T);
    end

    // State, counters and registered outputs.
    // NOTE: outputs are registered from the next-state decode so they change together with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_OFF;
            drv          <= 2'd0;
            hold_flag    <= 1'b0;
            ms_cnt       <= '0;
            idx_ms       <= '0;
            motor        <= 1'b0;
            ds_out       <= 4'b0000;
            hrdy         <= 1'b0;
            disk_present <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            drv          <= drv_nxt;
            hold_flag    <= flag_nxt;
            ms_cnt       <= ms_nxt;
            idx_ms       <= idx_ms_nxt;
            motor        <= motor_nxt;
            ds_out       <= ds_out_nxt;
            hrdy         <= hrdy_nxt;
            disk_present <= dp_nxt;
        end
    end

endmodule
